// File: rtl/tile_cl_inject.sv
// tile_cl_inject: injection endpoint from a tile's cache controller into the
// XY mesh cache-line FIFO node. Requests are buffered in a FIFO, launched one
// at a time, and retried after a backoff if the node rejects them. Packets
// addressed to this tile go out on the loopback port instead of the mesh.
// Optional build macro TILE_CL_INJECT_STATS_EN adds saturating statistics
// outputs stat_launch, stat_nack and stat_lb.
module tile_cl_inject #(
    parameter int TILE_X  = 0,
    parameter int TILE_Y  = 0,
    parameter int DEPTH   = 8,
    parameter int BACKOFF = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [527:0]             req_data,
    input  logic [36:0]              req_addr,
    input  logic [41:0]              req_size,
    input  logic                     req_expun,
    output logic                     out_en,
    output logic [527:0]             out_datum,
    output logic [36:0]              out_addr,
    output logic [41:0]              out_size,
    input  logic                     ring_busy,
    input  logic                     ring_nack,
    output logic                     lb_en,
    output logic [527:0]             lb_data,
    output logic [36:0]              lb_addr,
    output logic [41:0]              lb_size,
    output logic                     lb_expun,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef TILE_CL_INJECT_STATS_EN
    ,
    output logic [15:0]              stat_launch,
    output logic [15:0]              stat_nack,
    output logic [15:0]              stat_lb
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] TX = 2'(TILE_X);
    localparam logic [1:0] TY = 2'(TILE_Y);
    localparam logic [3:0] BO = 4'(BACKOFF);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BACK} state_t;

    logic [527:0]  mem_data  [DEPTH];
    logic [36:0]   mem_addr  [DEPTH];
    logic [41:0]   mem_size  [DEPTH];
    logic          mem_expun [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    bo_q, bo_d;
    logic          out_en_q, out_en_d, lb_en_q, lb_en_d, lb_expun_q, lb_expun_d;
    logic [527:0]  out_datum_q, out_datum_d, lb_data_q, lb_data_d;
    logic [36:0]   out_addr_q, out_addr_d, lb_addr_q, lb_addr_d;
    logic [41:0]   out_size_q, out_size_d, lb_size_q, lb_size_d;
`ifdef TILE_CL_INJECT_STATS_EN
    logic [15:0]   st_launch_q, st_launch_d, st_nack_q, st_nack_d, st_lb_q, st_lb_d;
`endif

    logic          push, pop, head_valid, head_local;
    logic [527:0]  head_data;
    logic [36:0]   head_addr;
    logic [41:0]   head_size;
    logic          head_expun;

    assign req_ready  = (count_q < CW'(DEPTH));
    assign push       = req_valid && req_ready;
    assign head_valid = (count_q != '0);
    assign head_data  = mem_data[rd_ptr_q];
    assign head_addr  = mem_addr[rd_ptr_q];
    assign head_size  = mem_size[rd_ptr_q];
    assign head_expun = mem_expun[rd_ptr_q];
    assign head_local = (head_addr[36:4] == '0) ||
                        (head_addr[1:0] == TX && head_addr[3:2] == TY);

    // FIFO storage: written on accepted requests, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q]  <= req_data;
            mem_addr[wr_ptr_q]  <= req_addr;
            mem_size[wr_ptr_q]  <= req_size;
            mem_expun[wr_ptr_q] <= req_expun;
        end
    end

    // Next-state: launch/loopback decisions, FIFO pointers, backoff, stats
    always_comb begin
        state_d     = state_q;
        bo_d        = bo_q;
        pop         = 1'b0;
        out_en_d    = 1'b0;
        lb_en_d     = 1'b0;
        out_datum_d = out_datum_q;
        out_addr_d  = out_addr_q;
        out_size_d  = out_size_q;
        lb_data_d   = lb_data_q;
        lb_addr_d   = lb_addr_q;
        lb_size_d   = lb_size_q;
        lb_expun_d  = lb_expun_q;
`ifdef TILE_CL_INJECT_STATS_EN
        st_launch_d = st_launch_q;
        st_nack_d   = st_nack_q;
        st_lb_d     = st_lb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (head_valid) begin
                    if (head_local) begin
                        lb_en_d    = 1'b1;
                        lb_data_d  = head_data;
                        lb_addr_d  = head_addr;
                        lb_size_d  = head_size;
                        lb_expun_d = head_expun;
                        pop        = 1'b1;
`ifdef TILE_CL_INJECT_STATS_EN
                        if (st_lb_q != '1) st_lb_d = st_lb_q + 16'd1;
`endif
                    end else if (!ring_busy) begin
                        out_en_d    = 1'b1;
                        out_datum_d = head_data;
                        out_addr_d  = head_addr;
                        out_size_d  = head_size;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ring_nack) begin
                    bo_d    = BO;
                    state_d = S_BACK;
`ifdef TILE_CL_INJECT_STATS_EN
                    if (st_nack_q != '1) st_nack_d = st_nack_q + 16'd1;
`endif
                end else begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
`ifdef TILE_CL_INJECT_STATS_EN
                    if (st_launch_q != '1) st_launch_d = st_launch_q + 16'd1;
`endif
                end
            end
            S_BACK: begin
                // Leave on the cycle the counter reaches zero, so the relaunch
                // strobe lands BACKOFF+2 cycles after the rejected one.
                bo_d = bo_q - 4'd1;
                if (bo_q <= 4'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // State and registered outputs; synchronous reset discards everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bo_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_en_q    <= 1'b0;
            lb_en_q     <= 1'b0;
            out_datum_q <= '0;
            out_addr_q  <= '0;
            out_size_q  <= '0;
            lb_data_q   <= '0;
            lb_addr_q   <= '0;
            lb_size_q   <= '0;
            lb_expun_q  <= 1'b0;
`ifdef TILE_CL_INJECT_STATS_EN
            st_launch_q <= '0;
            st_nack_q   <= '0;
            st_lb_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bo_q        <= bo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_en_q    <= out_en_d;
            lb_en_q     <= lb_en_d;
            out_datum_q <= out_datum_d;
            out_addr_q  <= out_addr_d;
            out_size_q  <= out_size_d;
            lb_data_q   <= lb_data_d;
            lb_addr_q   <= lb_addr_d;
            lb_size_q   <= lb_size_d;
            lb_expun_q  <= lb_expun_d;
`ifdef TILE_CL_INJECT_STATS_EN
            st_launch_q <= st_launch_d;
            st_nack_q   <= st_nack_d;
            st_lb_q     <= st_lb_d;
`endif
        end
    end

    assign out_en     = out_en_q;
    assign out_datum  = out_datum_q;
    assign out_addr   = out_addr_q;
    assign out_size   = out_size_q;
    assign lb_en      = lb_en_q;
    assign lb_data    = lb_data_q;
    assign lb_addr    = lb_addr_q;
    assign lb_size    = lb_size_q;
    assign lb_expun   = lb_expun_q;
    assign fifo_count = count_q;
`ifdef TILE_CL_INJECT_STATS_EN
    assign stat_launch = st_launch_q;
    assign stat_nack   = st_nack_q;
    assign stat_lb     = st_lb_q;
`endif

endmodule

// File: tb/tb_tile_cl_inject.sv
// Directed bench for tile_cl_inject with TILE_X=1, TILE_Y=2, DEPTH=8,
// BACKOFF=3. Payload fields are derived from the address so every entry is
// distinguishable; expected values are computed from the same formula.
module tb_tile_cl_inject;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_expun;
    logic [527:0] req_data;
    logic [36:0]  req_addr;
    logic [41:0]  req_size;
    logic         out_en;
    logic [527:0] out_datum;
    logic [36:0]  out_addr;
    logic [41:0]  out_size;
    logic         ring_busy, ring_nack;
    logic         lb_en, lb_expun;
    logic [527:0] lb_data;
    logic [36:0]  lb_addr;
    logic [41:0]  lb_size;
    logic [3:0]   fifo_count;
`ifdef TILE_CL_INJECT_STATS_EN
    logic [15:0]  stat_launch, stat_nack, stat_lb;
`endif

    int checks   = 0;
    int failures = 0;

    tile_cl_inject #(.TILE_X(1), .TILE_Y(2), .DEPTH(8), .BACKOFF(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_addr(req_addr), .req_size(req_size), .req_expun(req_expun),
        .out_en(out_en), .out_datum(out_datum), .out_addr(out_addr), .out_size(out_size),
        .ring_busy(ring_busy), .ring_nack(ring_nack),
        .lb_en(lb_en), .lb_data(lb_data), .lb_addr(lb_addr), .lb_size(lb_size),
        .lb_expun(lb_expun), .fifo_count(fifo_count)
`ifdef TILE_CL_INJECT_STATS_EN
        , .stat_launch(stat_launch), .stat_nack(stat_nack), .stat_lb(stat_lb)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [527:0] mk_data(input logic [36:0] a);
        return {16{a[32:0]}};
    endfunction

    function automatic logic [41:0] mk_size(input logic [36:0] a);
        return {a, 5'h15};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [36:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = mk_data(a);
        req_size  = mk_size(a);
        req_expun = a[4];
    endtask

    // One-cycle push of address a
    task automatic push(input logic [36:0] a);
        set_req(a);
        tick();
        req_valid = 1'b0;
    endtask

    logic [36:0] a_loc, a_rem, a_c, a_d, a_e, a_l0;
    logic [36:0] a_full [8];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_data = '0; req_addr = '0; req_size = '0;
        req_expun = 1'b0; ring_busy = 1'b0; ring_nack = 1'b0;
        a_loc = 37'h100_0009; a_rem = 37'h200_0003;
        a_c = 37'h210_0013; a_d = 37'h220_0023; a_e = 37'h230_0033;
        a_l0 = 37'h000_000F;
        for (int i = 0; i < 8; i++) a_full[i] = {29'(32'h300 + i), 8'h50};

        tick(); tick();
        chk("rst_out_en", out_en, 0);
        chk("rst_lb_en", lb_en, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_lb_data", lb_data, 0);
        rst = 1'b0;
        tick();

        // Local by coordinates: lb_en two cycles after the push
        push(a_loc);
        chk("lb_count1", fifo_count, 1);
        chk("lb_early", lb_en, 0);
        tick();
        chk("lb_en", lb_en, 1);
        chk("lb_addr", lb_addr, a_loc);
        chk("lb_data", lb_data, mk_data(a_loc));
        chk("lb_size", lb_size, mk_size(a_loc));
        chk("lb_expun", lb_expun, 0);
        chk("lb_no_out", out_en, 0);
        chk("lb_count0", fifo_count, 0);
        tick();
        chk("lb_pulse_end", lb_en, 0);
        chk("lb_hold", lb_addr, a_loc);
        chk("lb_never_out", out_en, 0);
`ifdef TILE_CL_INJECT_STATS_EN
        chk("stat_lb1", stat_lb, 1);
`endif

        // Remote launch, accepted
        push(a_rem);
        chk("rem_pre", out_en, 0);
        tick();
        chk("rem_en", out_en, 1);
        chk("rem_addr", out_addr, a_rem);
        chk("rem_data", out_datum, mk_data(a_rem));
        chk("rem_count_wait", fifo_count, 1);
        tick();
        chk("rem_en_off", out_en, 0);
        chk("rem_popped", fifo_count, 0);
        chk("rem_hold", out_addr, a_rem);

        // Back-to-back remote entries: launches two cycles apart
        set_req(a_c); tick();
        set_req(a_d); tick();
        req_valid = 1'b0;
        chk("c_en", out_en, 1);
        chk("c_addr", out_addr, a_c);
        chk("cd_count", fifo_count, 2);
        tick();
        chk("c_gap", out_en, 0);
        tick();
        chk("d_en", out_en, 1);
        chk("d_addr", out_addr, a_d);
        tick();
        chk("d_done", fifo_count, 0);
`ifdef TILE_CL_INJECT_STATS_EN
        chk("stat_launch3", stat_launch, 3);
`endif

        // Nack with BACKOFF=3: relaunch 5 cycles after the first strobe
        push(a_e);
        tick();
        chk("e_en", out_en, 1);
        ring_nack = 1'b1;
        tick();
        ring_nack = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("e_quiet%0d", k), out_en, 0);
            chk($sformatf("e_cnt%0d", k), fifo_count, 1);
            if (k < 4) tick();
        end
        tick();
        chk("e_relaunch", out_en, 1);
        chk("e_re_addr", out_addr, a_e);
        chk("e_re_data", out_datum, mk_data(a_e));
        tick();
        chk("e_popped", fifo_count, 0);
`ifdef TILE_CL_INJECT_STATS_EN
        chk("stat_nack1", stat_nack, 1);
`endif

        // Fill to DEPTH under ring_busy, then drain in order across wrap
        ring_busy = 1'b1;
        for (int i = 0; i < 8; i++) push(a_full[i]);
        chk("full_ready", req_ready, 0);
        chk("full_count", fifo_count, 8);
        chk("full_no_launch", out_en, 0);
        set_req(37'h1F_FFFF_FFF0);
        tick();
        req_valid = 1'b0;
        chk("full_reject", fifo_count, 8);
        ring_busy = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_en%0d", i), out_en, 1);
            chk($sformatf("drain_addr%0d", i), out_addr, a_full[i]);
            tick();
            chk($sformatf("drain_gap%0d", i), out_en, 0);
            tick();
        end
        chk("drain_empty", fifo_count, 0);
        chk("drain_ready", req_ready, 1);

        // Blocked remote head holds back a local entry behind it
        ring_busy = 1'b1;
        push(a_rem);
        push(a_l0);
        tick(); tick();
        chk("blk_no_lb", lb_en, 0);
        chk("blk_count", fifo_count, 2);
        ring_busy = 1'b0;
        tick();
        chk("blk_launch", out_en, 1);
        chk("blk_lb_still0", lb_en, 0);
        tick();
        chk("blk_pop_lb0", lb_en, 0);
        tick();
        chk("blk_lb_en", lb_en, 1);
        chk("blk_lb_addr", lb_addr, a_l0);
        chk("blk_lb_expun", lb_expun, 0);
        chk("blk_empty", fifo_count, 0);

        // Reset during WAIT with three queued entries
        ring_busy = 1'b1;
        push(a_c); push(a_d); push(a_e);
        ring_busy = 1'b0;
        tick();
        chk("rw_launch", out_en, 1);
        rst = 1'b1;
        tick();
        chk("rw_count", fifo_count, 0);
        chk("rw_out_en", out_en, 0);
        chk("rw_out_addr", out_addr, 0);
        chk("rw_ready", req_ready, 1);
`ifdef TILE_CL_INJECT_STATS_EN
        chk("rw_stat_launch", stat_launch, 0);
        chk("rw_stat_nack", stat_nack, 0);
        chk("rw_stat_lb", stat_lb, 0);
`endif
        rst = 1'b0;
        ring_nack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("rw_quiet%0d", k), out_en | lb_en, 0);
        end
        ring_nack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
